vga_mem_arbiter: RTL and testbench
==================================

Name: vga_mem_arbiter

Overview:
Shares the single 16-bit VGA SRAM Wishbone master port among three requesters: display fetch (read, real-time), CPU plane-write path (one stb/ack per plane access) and CPU read/latch-load path. Display fetch has strict priority, with a bounded starvation guard for the CPU ports. CPU write and read ports are served round-robin. A transaction timeout releases a hung access. Sits between the VGA write/read interfaces plus the CRTC fetch unit and the SRAM controller.

Parameters:
CPU_MAX_WAIT, 8, consecutive display grants after which a pending CPU request wins the next decision (1..15).
TIMEOUT, 255, cycles in BUSY without sram_ack_i before forced completion; 0 disables.

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  reset; one clock; reset is asynchronous and active-low
d_adr_i  in  17  display read word address [17:1]
d_stb_i  in  1  display request
d_ack_o  out  1  display ack
d_dat_o  out  16  display read data
w_adr_i  in  17  CPU write address [17:1] (plane in [17:16])
w_sel_i  in  2  CPU write byte selects
w_dat_i  in  16  CPU write data
w_stb_i  in  1  CPU write request
w_ack_o  out  1  CPU write ack
r_adr_i  in  17  CPU read address [17:1]
r_stb_i  in  1  CPU read request
r_ack_o  out  1  CPU read ack
r_dat_o  out  16  CPU read data
sram_adr_o  out  17  master address
sram_sel_o  out  2  master byte selects
sram_dat_o  out  16  master write data
sram_we_o  out  1  master write enable
sram_stb_o  out  1  master strobe (also cycle)
sram_dat_i  in  16  master read data
sram_ack_i  in  1  master ack
gnt_o  out  2  current grant: 0 none, 1 display, 2 write, 3 read
timeout_o  out  1  one-cycle pulse on forced completion

Behaviour:
- Reset (async, wb_rst_ni=0): state IDLE, gnt_o=0, all acks 0, sram_stb_o=0, sram_we_o=0, timeout_o=0, last_cpu=read (so write wins first tie), wait_cnt=0, to_cnt=0. Outputs drop immediately on assertion, even mid-transaction; no ack is issued for an aborted access.
- FSM: IDLE -> BUSY when any stb is high at a clock edge (grant registered at that edge); BUSY -> IDLE on sram_ack_i, timeout, or granted stb dropping.
- Arbitration in IDLE, evaluated on the stb values at the edge:
  - if d_stb_i and no CPU starvation flag -> display;
  - else if w_stb_i and r_stb_i -> the port opposite last_cpu;
  - else the single requesting CPU port.
- Starvation guard: wait_cnt increments when display wins while a CPU stb is high, saturating at CPU_MAX_WAIT. When wait_cnt==CPU_MAX_WAIT, the next decision goes to a CPU port. wait_cnt clears on any CPU grant.
- BUSY outputs, combinational from the grant register:
  - sram_adr_o = granted address; sram_stb_o = granted stb.
  - write port: sram_we_o=1, sram_sel_o=w_sel_i, sram_dat_o=w_dat_i.
  - read ports: sram_we_o=0, sram_sel_o=2'b11, sram_dat_o=0.
  - In IDLE all master outputs are 0.
- Ack routing: the granted requester's ack = sram_ack_i in the same cycle. d_dat_o/r_dat_o = sram_dat_i when granted, otherwise 0. Non-granted acks are always 0.
- A transaction costs 1 arbitration cycle plus slave latency. One IDLE cycle always separates accesses, so a requester must drop or renew stb after its ack.
- last_cpu updates on each CPU grant.
- Timeout: to_cnt counts BUSY cycles, clearing on entry. If to_cnt reaches TIMEOUT-1 with sram_ack_i low:
  - pulse the granted ack for 1 cycle with data 16'hFFFF;
  - pulse timeout_o;
  - go to IDLE.
  - TIMEOUT=0 disables this.
- Granted stb low in BUSY (protocol violation): sram_stb_o falls the same cycle, return to IDLE, no ack.
- Simultaneous sram_ack_i and timeout in the same cycle: treated as a normal ack; timeout_o stays 0.

Test Plan:
- Write alone: w_stb_i=1, w_adr_i=17'h10020, w_dat_i=16'hA55A, sel=2'b01, slave ack after 2 cycles -> gnt_o=2, sram_we_o=1, sram_adr_o=17'h10020, sram_dat_o=16'hA55A, w_ack_o high exactly 1 cycle, 3 cycles edge-to-ack.
- Four write_iface plane writes interleaved with a continuous r_stb_i -> grants alternate write, read, write, read; each separated by one IDLE cycle.
- d_stb_i held high with w_stb_i pending, CPU_MAX_WAIT=8 -> 8 display grants, then 1 write grant, then display resumes.
- Read with sram_dat_i=16'h1234 -> r_dat_o=16'h1234 on the r_ack_o cycle; d_dat_o=0.
- Slave never acks, TIMEOUT=255 -> 255 BUSY cycles then one d_ack_o pulse with d_dat_o=16'hFFFF and a timeout_o pulse; the next request is granted normally.
- Reset asserted in BUSY -> sram_stb_o and gnt_o are 0 before the next edge, no ack; after release, write wins a simultaneous read/write request.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// Arbiter sharing the VGA SRAM Wishbone master among display fetch, CPU write and CPU read.
// Display has priority with a starvation guard; CPU ports alternate; hung accesses time out.
module vga_mem_arbiter #(
  parameter int unsigned CPU_MAX_WAIT = 8,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [16:0] d_adr_i,
  input  logic        d_stb_i,
  output logic        d_ack_o,
  output logic [15:0] d_dat_o,
  input  logic [16:0] w_adr_i,
  input  logic [1:0]  w_sel_i,
  input  logic [15:0] w_dat_i,
  input  logic        w_stb_i,
  output logic        w_ack_o,
  input  logic [16:0] r_adr_i,
  input  logic        r_stb_i,
  output logic        r_ack_o,
  output logic [15:0] r_dat_o,
  output logic [16:0] sram_adr_o,
  output logic [1:0]  sram_sel_o,
  output logic [15:0] sram_dat_o,
  output logic        sram_we_o,
  output logic        sram_stb_o,
  input  logic [15:0] sram_dat_i,
  input  logic        sram_ack_i,
  output logic [1:0]  gnt_o,
  output logic        timeout_o
);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_WR   = 2'd2,
    GNT_RD   = 2'd3
  } gnt_e;

  localparam int unsigned     TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [3:0]      WAIT_MAX = 4'(CPU_MAX_WAIT);

  state_e          state_q, state_d;
  gnt_e            gnt_q, gnt_d;
  logic            last_rd_q, last_rd_d;
  logic [3:0]      wait_q, wait_d;
  logic [TO_W-1:0] to_q, to_d;

  logic        starve;
  logic        gstb;
  logic        to_hit;
  logic        ack;
  logic [15:0] rdata;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_NONE;
      last_rd_q <= 1'b1;
      wait_q    <= '0;
      to_q      <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_rd_q <= last_rd_d;
      wait_q    <= wait_d;
      to_q      <= to_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_rd_d = last_rd_q;
    wait_d    = wait_q;
    to_d      = to_q;

    sram_adr_o = '0;
    sram_sel_o = '0;
    sram_dat_o = '0;
    sram_we_o  = 1'b0;
    sram_stb_o = 1'b0;
    d_ack_o    = 1'b0;
    w_ack_o    = 1'b0;
    r_ack_o    = 1'b0;
    d_dat_o    = '0;
    r_dat_o    = '0;
    timeout_o  = 1'b0;

    starve = (wait_q == WAIT_MAX);

    case (gnt_q)
      GNT_DISP: gstb = d_stb_i;
      GNT_WR:   gstb = w_stb_i;
      GNT_RD:   gstb = r_stb_i;
      default:  gstb = 1'b0;
    endcase

    // A same-cycle slave ack takes precedence over a forced completion.
    to_hit = TO_EN && (to_q == TO_LAST) && gstb && !sram_ack_i;
    ack    = gstb && (sram_ack_i || to_hit);
    rdata  = to_hit ? 16'hFFFF : sram_dat_i;

    case (state_q)
      IDLE: begin
        if (d_stb_i || w_stb_i || r_stb_i) begin
          state_d = BUSY;
          to_d    = '0;
          if (d_stb_i && !starve)       gnt_d = GNT_DISP;
          else if (w_stb_i && r_stb_i)  gnt_d = last_rd_q ? GNT_WR : GNT_RD;
          else if (w_stb_i)             gnt_d = GNT_WR;
          else if (r_stb_i)             gnt_d = GNT_RD;
          else                          gnt_d = GNT_DISP;

          if (gnt_d == GNT_DISP) begin
            if ((w_stb_i || r_stb_i) && !starve) wait_d = wait_q + 4'd1;
          end else begin
            wait_d    = '0;
            last_rd_d = (gnt_d == GNT_RD);
          end
        end
      end

      BUSY: begin
        sram_stb_o = gstb;
        timeout_o  = to_hit;
        case (gnt_q)
          GNT_DISP: begin
            sram_adr_o = d_adr_i;
            sram_sel_o = 2'b11;
            d_ack_o    = ack;
            d_dat_o    = rdata;
          end
          GNT_WR: begin
            sram_adr_o = w_adr_i;
            sram_sel_o = w_sel_i;
            sram_dat_o = w_dat_i;
            sram_we_o  = 1'b1;
            w_ack_o    = ack;
          end
          GNT_RD: begin
            sram_adr_o = r_adr_i;
            sram_sel_o = 2'b11;
            r_ack_o    = ack;
            r_dat_o    = rdata;
          end
          default: ;
        endcase

        if (!gstb || sram_ack_i || to_hit) begin
          state_d = IDLE;
          gnt_d   = GNT_NONE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        gnt_d   = GNT_NONE;
      end
    endcase
  end

  assign gnt_o = gnt_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed and randomized bench for vga_mem_arbiter against a transaction-level reference model.
module tb_vga_mem_arbiter;

  localparam int MAXW = 8;
  localparam int TOUT = 255;

  logic        clk;
  logic        rst_n;
  logic [16:0] d_adr_i, w_adr_i, r_adr_i;
  logic        d_stb_i, w_stb_i, r_stb_i;
  logic [1:0]  w_sel_i;
  logic [15:0] w_dat_i;
  logic        d_ack_o, w_ack_o, r_ack_o;
  logic [15:0] d_dat_o, r_dat_o;
  logic [16:0] sram_adr_o;
  logic [1:0]  sram_sel_o;
  logic [15:0] sram_dat_o;
  logic        sram_we_o, sram_stb_o;
  logic [15:0] sram_dat_i;
  logic        sram_ack_i;
  logic [1:0]  gnt_o;
  logic        timeout_o;

  int n_chk  = 0;
  int n_pass = 0;

  vga_mem_arbiter #(.CPU_MAX_WAIT(MAXW), .TIMEOUT(TOUT)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .d_adr_i(d_adr_i), .d_stb_i(d_stb_i), .d_ack_o(d_ack_o), .d_dat_o(d_dat_o),
    .w_adr_i(w_adr_i), .w_sel_i(w_sel_i), .w_dat_i(w_dat_i), .w_stb_i(w_stb_i), .w_ack_o(w_ack_o),
    .r_adr_i(r_adr_i), .r_stb_i(r_stb_i), .r_ack_o(r_ack_o), .r_dat_o(r_dat_o),
    .sram_adr_o(sram_adr_o), .sram_sel_o(sram_sel_o), .sram_dat_o(sram_dat_o),
    .sram_we_o(sram_we_o), .sram_stb_o(sram_stb_o), .sram_dat_i(sram_dat_i),
    .sram_ack_i(sram_ack_i), .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500000");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Runs one access from the grant edge to the acked cycle; returns at the following IDLE cycle.
  task automatic serve(input int lat, input logic [15:0] rdat, output logic [1:0] g,
                       output logic [2:0] acks, output logic [15:0] dd, output logic [15:0] rd,
                       output logic [19:0] bus);
    tick();
    #1;
    g   = gnt_o;
    bus = {sram_we_o, sram_sel_o, sram_adr_o};
    repeat (lat - 1) tick();
    sram_ack_i = 1'b1;
    sram_dat_i = rdat;
    #1;
    acks = {d_ack_o, w_ack_o, r_ack_o};
    dd   = d_dat_o;
    rd   = r_dat_o;
    tick();
    sram_ack_i = 1'b0;
    sram_dat_i = '0;
  endtask

  // Reference model state: owner 0 none / 1 display / 2 write / 3 read.
  int m_own, m_busy, m_streak;
  bit m_lastw;

  function automatic int decide(bit d, bit w, bit r);
    if (d && m_streak != MAXW) return 1;
    if (w && r) return m_lastw ? 3 : 2;
    if (w) return 2;
    if (r) return 3;
    if (d) return 1;
    return 0;
  endfunction

  initial begin
    logic [1:0]  g;
    logic [2:0]  acks;
    logic [15:0] dd, rd;
    logic [19:0] bus;
    int          at;
    logic        to_seen, to_early;
    logic [15:0] to_dat;
    bit   [3:1]  st;
    bit   [3:1]  pack;
    logic [16:0] ad [1:3];
    logic [74:0] expv, obsv;
    logic        gs, th, ak;
    logic [15:0] rdv;
    int          w;

    rst_n = 1'b0;
    d_adr_i = 17'h00100; w_adr_i = 17'h00200; r_adr_i = 17'h00300;
    d_stb_i = 1'b1; w_stb_i = 1'b1; r_stb_i = 1'b1;
    w_sel_i = 2'b11; w_dat_i = 16'hDEAD;
    sram_ack_i = 1'b1; sram_dat_i = 16'h5555;

    // Reset state with every input active
    tick(); #1;
    chk("rst_gnt", 80'(gnt_o), 80'(0));
    chk("rst_bus", 80'({sram_stb_o, sram_we_o, timeout_o}), 80'(0));
    chk("rst_acks", 80'({d_ack_o, w_ack_o, r_ack_o}), 80'(0));
    tick();
    rst_n = 1'b1; d_stb_i = 1'b0; w_stb_i = 1'b0; r_stb_i = 1'b0;
    sram_ack_i = 1'b0; sram_dat_i = '0;
    tick();

    // Round-robin: four plane writes against a continuous read request
    r_stb_i = 1'b1; r_adr_i = 17'h00777;
    w_stb_i = 1'b1; w_adr_i = {2'd0, 15'h0123}; w_dat_i = 16'h1111; w_sel_i = 2'b11;
    at = 0;
    for (int i = 0; i < 8; i++) begin
      serve(2, 16'h0F0F, g, acks, dd, rd, bus);
      chk($sformatf("rr_gnt%0d", i), 80'(g), 80'((i % 2 == 0) ? 2 : 3));
      chk($sformatf("rr_ack%0d", i), 80'(acks), 80'((i % 2 == 0) ? 3'b010 : 3'b001));
      if (g == 2'd2) begin
        at++;
        if (at == 4) w_stb_i = 1'b0;
        else w_adr_i = {2'(at), 15'h0123};
      end
      #1;
      chk($sformatf("rr_idle%0d", i), 80'(gnt_o), 80'(0));
      tick();
    end
    r_stb_i = 1'b0;
    tick();

    // Write alone with a slave acking on the third busy cycle
    w_stb_i = 1'b1; w_adr_i = 17'h10020; w_dat_i = 16'hA55A; w_sel_i = 2'b01;
    #1;
    chk("wr_pre_gnt", 80'(gnt_o), 80'(0));
    tick(); #1;
    chk("wr_gnt", 80'(gnt_o), 80'(2));
    chk("wr_bus", 80'({sram_stb_o, sram_we_o, sram_sel_o, sram_adr_o, sram_dat_o}),
        80'({1'b1, 1'b1, 2'b01, 17'h10020, 16'hA55A}));
    chk("wr_noack1", 80'(w_ack_o), 80'(0));
    tick(); #1;
    chk("wr_noack2", 80'(w_ack_o), 80'(0));
    tick();
    sram_ack_i = 1'b1;
    #1;
    chk("wr_ack", 80'({d_ack_o, w_ack_o, r_ack_o}), 80'(3'b010));
    tick();
    sram_ack_i = 1'b0; w_stb_i = 1'b0;
    #1;
    chk("wr_after", 80'({gnt_o, w_ack_o}), 80'(0));
    tick();

    // Read data routing
    r_stb_i = 1'b1; r_adr_i = 17'h0ABCD;
    serve(2, 16'h1234, g, acks, dd, rd, bus);
    r_stb_i = 1'b0;
    chk("rd_gnt", 80'(g), 80'(3));
    chk("rd_bus", 80'(bus), 80'({1'b0, 2'b11, 17'h0ABCD}));
    chk("rd_ack", 80'(acks), 80'(3'b001));
    chk("rd_dat", 80'({rd, dd}), 80'({16'h1234, 16'h0000}));
    tick();

    // Starvation guard
    d_stb_i = 1'b1; d_adr_i = 17'h00040;
    w_stb_i = 1'b1; w_adr_i = 17'h00050; w_sel_i = 2'b10; w_dat_i = 16'h7777;
    for (int i = 0; i < 10; i++) begin
      serve(1, 16'h2222, g, acks, dd, rd, bus);
      chk($sformatf("starve_gnt%0d", i), 80'(g), 80'((i == 8) ? 2 : 1));
      if (g == 2'd2) w_stb_i = 1'b0;
    end
    d_stb_i = 1'b0; w_stb_i = 1'b0;
    tick();

    // Timeout on a hung display access
    d_stb_i = 1'b1;
    tick();
    at = 0; to_seen = 1'b0; to_early = 1'b0; to_dat = '0;
    for (int k = 1; k <= 300; k++) begin
      #1;
      if (k == TOUT - 1) to_early = timeout_o;
      if (d_ack_o) begin
        at = k; to_seen = timeout_o; to_dat = d_dat_o;
        break;
      end
      tick();
    end
    chk("to_cycle", 80'(at), 80'(TOUT));
    chk("to_dat", 80'(to_dat), 80'(16'hFFFF));
    chk("to_pulse", 80'({to_early, to_seen}), 80'(2'b01));
    tick();
    d_stb_i = 1'b0;
    #1;
    chk("to_idle", 80'({gnt_o, timeout_o}), 80'(0));
    tick();
    w_stb_i = 1'b1; w_sel_i = 2'b11;
    serve(1, 16'h0, g, acks, dd, rd, bus);
    w_stb_i = 1'b0;
    chk("to_next", 80'({g, acks}), 80'({2'd2, 3'b010}));
    tick();

    // Ack arriving in the timeout cycle is a normal completion
    d_stb_i = 1'b1;
    tick();
    repeat (TOUT - 1) tick();
    sram_ack_i = 1'b1; sram_dat_i = 16'h0BEE;
    #1;
    chk("to_race", 80'({d_ack_o, d_dat_o, timeout_o}), 80'({1'b1, 16'h0BEE, 1'b0}));
    tick();
    sram_ack_i = 1'b0; sram_dat_i = '0; d_stb_i = 1'b0;
    tick();

    // Granted stb dropped mid-access
    w_stb_i = 1'b1;
    tick(); #1;
    chk("drop_gnt", 80'(gnt_o), 80'(2));
    tick();
    w_stb_i = 1'b0;
    #1;
    chk("drop_stb", 80'({sram_stb_o, w_ack_o}), 80'(0));
    tick(); #1;
    chk("drop_idle", 80'(gnt_o), 80'(0));
    tick();

    // Reset in BUSY after a write grant, then a write/read tie
    w_stb_i = 1'b1;
    tick(); #2;
    rst_n = 1'b0; sram_ack_i = 1'b1;
    #1;
    chk("rstb_out", 80'({gnt_o, sram_stb_o, w_ack_o, sram_we_o}), 80'(0));
    tick();
    rst_n = 1'b1; sram_ack_i = 1'b0; r_stb_i = 1'b1;
    serve(1, 16'h0, g, acks, dd, rd, bus);
    w_stb_i = 1'b0; r_stb_i = 1'b0;
    chk("rstb_tie", 80'(g), 80'(2));
    tick();

    // Randomized traffic against the reference model
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    m_own = 0; m_busy = 0; m_streak = 0; m_lastw = 1'b0;
    st = '0; pack = '0;
    ad[1] = '0; ad[2] = '0; ad[3] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int p = 1; p <= 3; p++) begin
        if (st[p]) begin
          if (pack[p]) begin
            if ($urandom_range(0, 1) == 1) ad[p] = 17'($urandom);
            else st[p] = 1'b0;
          end else if (m_own == p && $urandom_range(0, 99) < 3) begin
            st[p] = 1'b0;
          end
        end else if ($urandom_range(0, 99) < 40) begin
          st[p] = 1'b1;
          ad[p] = 17'($urandom);
        end
      end
      if (st[2] && (pack[2] || !w_stb_i)) begin
        w_dat_i = 16'($urandom);
        w_sel_i = 2'($urandom);
      end
      d_stb_i = st[1]; w_stb_i = st[2]; r_stb_i = st[3];
      d_adr_i = ad[1]; w_adr_i = ad[2]; r_adr_i = ad[3];
      sram_ack_i = (m_own != 0) && ($urandom_range(0, 2) == 0 || m_busy >= 4);
      sram_dat_i = 16'($urandom);
      #1;

      gs  = (m_own != 0) && st[m_own];
      th  = (m_own != 0) && (TOUT != 0) && (m_busy == TOUT - 1) && gs && !sram_ack_i;
      ak  = gs && (sram_ack_i || th);
      rdv = th ? 16'hFFFF : sram_dat_i;
      expv = '0;
      if (m_own != 0) begin
        expv = {2'(m_own), (m_own == 1) && ak, (m_own == 2) && ak, (m_own == 3) && ak, th, gs,
                m_own == 2, (m_own == 2) ? w_sel_i : 2'b11, ad[m_own],
                (m_own == 2) ? w_dat_i : 16'h0000,
                (m_own == 1) ? rdv : 16'h0000, (m_own == 3) ? rdv : 16'h0000};
      end
      obsv = {gnt_o, d_ack_o, w_ack_o, r_ack_o, timeout_o, sram_stb_o, sram_we_o, sram_sel_o,
              sram_adr_o, sram_dat_o, d_dat_o, r_dat_o};
      chk($sformatf("rand%0d", cyc), 80'(obsv), 80'(expv));

      pack = '0;
      if (m_own != 0) pack[m_own] = ak;
      if (m_own == 0) begin
        if (st != 0) begin
          w = decide(st[1], st[2], st[3]);
          if (w == 1 && (st[2] || st[3])) m_streak = (m_streak < MAXW) ? m_streak + 1 : MAXW;
          if (w >= 2) begin
            m_streak = 0;
            m_lastw  = (w == 2);
          end
          m_own  = w;
          m_busy = 0;
        end
      end else if (!gs || sram_ack_i || th) begin
        m_own = 0;
      end else begin
        m_busy++;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
